// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_t;

  localparam int CLK_HZ_DEFAULT   = 50000000;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  // Prescaler width to hold 0..div-1; never narrower than one bit.
  function automatic int prescaler_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_control_button_debouncer.sv
// Raw pushbutton to one-cycle press pulse: 2-flop synchroniser, run-length debounce.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          stable;
  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b != stable) begin
        // Accept the new level on the Nth consecutive differing sample.
        if (count == LAST) begin
          stable <= sync_b;
          count  <= '0;
          press  <= sync_b;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch run/pause/lap sequencer with debounced buttons and tick prescaler.
//   state   | meaning
//   IDLE    | cleared, not counting
//   RUNNING | counting, display live
//   PAUSED  | not counting, prescaler progress held
//   LAP     | counting, display frozen
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic btn_lap,
  output logic running,
  output logic tick,
  output logic clear,
  output logic freeze
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = prescaler_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic          press_start_stop;
  logic          press_clear;
  logic          press_lap;
  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clock(clock), .reset(reset), .raw(btn_start_stop), .press(press_start_stop)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clock(clock), .reset(reset), .raw(btn_clear), .press(press_clear)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clock(clock), .reset(reset), .raw(btn_lap), .press(press_lap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Priority: clear over start_stop over lap; losers in the same cycle are dropped.
  always_comb begin
    state_next = state;
    running    = (state == RUNNING) || (state == LAP);
    freeze     = (state == LAP);
    if (press_clear) begin
      state_next = IDLE;
    end else if (press_start_stop) begin
      case (state)
        IDLE, PAUSED: state_next = RUNNING;
        RUNNING, LAP: state_next = PAUSED;
        default:      state_next = IDLE;
      endcase
    end else if (press_lap) begin
      case (state)
        RUNNING: state_next = LAP;
        LAP:     state_next = RUNNING;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      tick      <= 1'b0;
      clear     <= 1'b0;
    end else begin
      clear <= press_clear;
      tick  <= 1'b0;
      if (press_clear) begin
        prescaler <= '0;
      end else if (running) begin
        if (prescaler == LAST) begin
          prescaler <= '0;
          tick      <= 1'b1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

endmodule
